// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types for the serial pattern-detector run controller.
// Holds the run-state encoding, the default pattern width with its derived
// length-field width, and the end-of-run status pair.
package seq_detect_pkg;

    localparam int SEQ_PAT_W_MAX = 8;
    localparam int SEQ_LEN_W     = $clog2(SEQ_PAT_W_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic hit;
        logic timeout;
    } status_t;

    localparam status_t STATUS_CLEAR = '{hit: 1'b0, timeout: 1'b0};

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit history, fill tracking and masked pattern compare.
// The newest bit enters history[0], so the low len bits hold the last len bits
// with the earliest of them at [len-1], lining up directly with the pattern.
// match is combinational on the bit being consumed this cycle.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W_MAX,
    parameter int LEN_W = SEQ_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_take,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             match
);

    logic [PAT_W-1:0] history_q;
    logic [PAT_W-1:0] history_next;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] fill_q;
    logic [LEN_W-1:0] fill_next;

    // Candidate history/fill if this bit is consumed, plus the active-length mask.
    always_comb begin
        history_next = {history_q[PAT_W-2:0], bit_in};
        fill_next    = (fill_q < len) ? fill_q + 1'b1 : len;
        len_mask     = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
    end

    assign match = bit_take && (fill_next >= len)
                   && (((history_next ^ pattern) & len_mask) == '0);

    // History and fill: cleared at run start and, without overlap, after each match.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history_q <= '0;
            fill_q    <= '0;
        end else if (bit_take) begin
            if (match && !overlap) begin
                history_q <= '0;
                fill_q    <= '0;
            end else begin
                history_q <= history_next;
                fill_q    <= fill_next;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for a programmable serial pattern detector.
// Takes a config over valid/ready, arms on start, counts matches and ends a run
// on threshold, window expiry or abort.
// Optional build macro SEQ_DETECT_CTRL_STATS_EN adds the bit_count output.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  ST_IDLE | accepting config; start arms a run once a legal config exists
//  ST_RUN  | consuming qualified bits, counting matches
//  ST_DONE | run finished; hit/timeout held until start or abort
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W_MAX = SEQ_PAT_W_MAX,
    parameter int CNT_W     = 16,
    parameter int WIN_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [PAT_W_MAX-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W_MAX+1)-1:0]   cfg_len,
    input  logic                             cfg_overlap,
    input  logic [CNT_W-1:0]                 cfg_threshold,
    input  logic [WIN_W-1:0]                 cfg_window,
    output logic                             cfg_err,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             bit_valid,
    input  logic                             bit_in,
    output logic                             match,
    output logic                             busy,
    output logic                             done,
    output logic                             hit,
    output logic                             timeout,
    output logic [CNT_W-1:0]                 match_count
`ifdef SEQ_DETECT_CTRL_STATS_EN
    ,
    output logic [WIN_W-1:0]                 bit_count
`endif
);

    localparam int               LEN_W   = $clog2(PAT_W_MAX + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state_q;
    status_t              status_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 cfg_ready_q;
    logic                 cfg_err_q;
    logic                 have_cfg_q;
    logic [PAT_W_MAX-1:0] pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovl_q;
    logic [CNT_W-1:0]     thr_q;
    logic [WIN_W-1:0]     win_q;
    logic [CNT_W-1:0]     count_q;
    logic [WIN_W-1:0]     win_rem_q;

    logic                 cfg_hs;
    logic                 len_legal;
    logic                 start_run;
    logic                 bit_take;
    logic                 core_match;
    logic [CNT_W-1:0]     count_next;
    logic [CNT_W-1:0]     thr_eff;
    logic                 thr_hit;
    logic                 win_end;

    // Handshake, run-start qualification and end-of-run conditions for this bit.
    always_comb begin
        cfg_hs     = cfg_ready_q && cfg_valid;
        len_legal  = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        start_run  = ((state_q == ST_IDLE) && start && have_cfg_q && !cfg_hs)
                     || ((state_q == ST_DONE) && start && !abort);
        bit_take   = (state_q == ST_RUN) && bit_valid && !abort;
        count_next = (core_match && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;
        thr_eff    = (thr_q == '0) ? CNT_W'(1) : thr_q;
        thr_hit    = (count_next >= thr_eff);
        win_end    = (win_q != '0) && (win_rem_q == WIN_W'(1));
    end

    seq_match_core #(
        .PAT_W (PAT_W_MAX),
        .LEN_W (LEN_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_run),
        .bit_take (bit_take),
        .bit_in   (bit_in),
        .pattern  (pat_q),
        .len      (len_q),
        .overlap  (ovl_q),
        .match    (core_match)
    );

    // Run FSM with registered status outputs, config latch and window down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            status_q    <= STATUS_CLEAR;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            have_cfg_q  <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            thr_q       <= '0;
            win_q       <= '0;
            count_q     <= '0;
            win_rem_q   <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_hs) begin
                        if (len_legal) begin
                            have_cfg_q <= 1'b1;
                            pat_q      <= cfg_pattern;
                            len_q      <= cfg_len;
                            ovl_q      <= cfg_overlap;
                            thr_q      <= cfg_threshold;
                            win_q      <= cfg_window;
                        end else begin
                            cfg_err_q  <= 1'b1;
                        end
                    end else if (start_run) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                        count_q     <= '0;
                        win_rem_q   <= win_q;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        status_q    <= STATUS_CLEAR;
                    end else if (bit_take) begin
                        count_q <= count_next;
                        if (win_q != '0) begin
                            win_rem_q <= win_rem_q - 1'b1;
                        end
                        if (thr_hit) begin
                            state_q          <= ST_DONE;
                            busy_q           <= 1'b0;
                            done_q           <= 1'b1;
                            status_q.hit     <= 1'b1;
                            status_q.timeout <= 1'b0;
                        end else if (win_end) begin
                            state_q          <= ST_DONE;
                            busy_q           <= 1'b0;
                            done_q           <= 1'b1;
                            status_q.hit     <= 1'b0;
                            status_q.timeout <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        status_q    <= STATUS_CLEAR;
                    end else if (start_run) begin
                        state_q   <= ST_RUN;
                        done_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        status_q  <= STATUS_CLEAR;
                        count_q   <= '0;
                        win_rem_q <= win_q;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                    status_q    <= STATUS_CLEAR;
                end
            endcase
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign cfg_err     = cfg_err_q;
    assign match       = core_match;
    assign busy        = busy_q;
    assign done        = done_q;
    assign hit         = status_q.hit;
    assign timeout     = status_q.timeout;
    assign match_count = count_q;

`ifdef SEQ_DETECT_CTRL_STATS_EN
    logic [WIN_W-1:0] bits_q;

    // Bits consumed in the current/last run, saturating, restarted on each run start.
    always_ff @(posedge clk) begin
        if (reset || start_run) begin
            bits_q <= '0;
        end else if (bit_take && (bits_q != '1)) begin
            bits_q <= bits_q + 1'b1;
        end
    end

    assign bit_count = bits_q;
`endif

endmodule
